// File: rtl/uart_rx_pkg.sv
// Shared state encoding, parity-type and prescale constants for the UART receive controller.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int unsigned PRESC_8  = 8;
  localparam int unsigned PRESC_16 = 16;
  localparam int unsigned PRESC_32 = 32;

endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// Oversampling edge counter (0..Prescale-1) and bit counter; both held at zero while disabled.
module uart_rx_edge_bit_counter #(
  parameter int unsigned PRESCALE_WIDTH = 6,
  parameter int unsigned BIT_CNT_WIDTH  = 4
) (
  input  logic                      CLK,
  input  logic                      Reset,
  input  logic                      enable,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  output logic [PRESCALE_WIDTH-1:0] edge_cnt,
  output logic [BIT_CNT_WIDTH-1:0]  bit_cnt,
  output logic                      wrap
);

  assign wrap = enable && (edge_cnt == (Prescale - PRESCALE_WIDTH'(1)));

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (!enable) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (wrap) begin
      edge_cnt <= '0;
      bit_cnt  <= bit_cnt + BIT_CNT_WIDTH'(1);
    end else begin
      edge_cnt <= edge_cnt + PRESCALE_WIDTH'(1);
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART RX frame controller: start detect, bit sequencing, parity and stop checks.
// Optional break detection output brk_det under UART_RX_BREAK_DET_EN.
import uart_rx_pkg::*;

module uart_rx_ctrl #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned PRESCALE_WIDTH = 6
) (
  input  logic                      CLK,
  input  logic                      Reset,
  input  logic                      RX_IN,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic                      sampled_data,
  input  logic                      sampled,
  input  logic [DATA_WIDTH-1:0]     P_Data,
`ifdef UART_RX_BREAK_DET_EN
  output logic                      brk_det,
`endif
  output logic [PRESCALE_WIDTH-1:0] edge_cnt,
  output logic                      sample_en,
  output logic                      deser_en,
  output logic                      data_valid,
  output logic                      par_err,
  output logic                      stp_err
);

  localparam int unsigned BIT_W = $clog2(DATA_WIDTH + 3);
  // The bit counter also counts the start bit, so data bit i is count i+1.
  localparam logic [BIT_W-1:0] LAST_DATA_BIT = BIT_W'(DATA_WIDTH);

  rx_state_t                 state;
  logic [PRESCALE_WIDTH-1:0] presc_q;
  logic                      par_en_q;
  logic                      par_typ_q;
  logic [BIT_W-1:0]          bit_cnt;
  logic                      wrap;
  logic                      stop_fault;

  assign sample_en = (state != IDLE);
  assign deser_en  = (state == DATA);

  uart_rx_edge_bit_counter #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH),
    .BIT_CNT_WIDTH (BIT_W)
  ) u_cnt (
    .CLK     (CLK),
    .Reset   (Reset),
    .enable  (sample_en),
    .Prescale(presc_q),
    .edge_cnt(edge_cnt),
    .bit_cnt (bit_cnt),
    .wrap    (wrap)
  );

`ifdef UART_RX_BREAK_DET_EN
  logic is_break;
  assign is_break   = !sampled_data && (P_Data == '0);
  assign stop_fault = !sampled_data && !is_break;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) brk_det <= 1'b0;
    else        brk_det <= (state == STOP) && sampled && is_break;
  end
`else
  assign stop_fault = !sampled_data;
`endif

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state      <= IDLE;
      presc_q    <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      case (state)
        IDLE: if (!RX_IN) begin
          state     <= START;
          presc_q   <= Prescale;
          par_en_q  <= PAR_EN;
          par_typ_q <= PAR_TYP;
          par_err   <= 1'b0;
          stp_err   <= 1'b0;
        end
        START: begin
          if (sampled && sampled_data) state <= IDLE;
          else if (wrap)               state <= DATA;
        end
        DATA: if (wrap && (bit_cnt == LAST_DATA_BIT)) begin
          state <= par_en_q ? PARITY : STOP;
        end
        PARITY: begin
          if (sampled) par_err <= sampled_data ^ (^P_Data) ^ (par_typ_q == PAR_ODD);
          if (wrap)    state   <= STOP;
        end
        STOP: if (sampled) begin
          // Leave at mid-stop so a back-to-back start edge is never missed.
          stp_err    <= stop_fault;
          data_valid <= !par_err && sampled_data;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: behavioural sampler/deserializer around the DUT,
// directed frame table, hand-written corner sequences and randomized frames.
module tb_uart_rx_ctrl;
  import uart_rx_pkg::*;

  localparam int unsigned DW = 8;
  localparam int unsigned PW = 6;
`ifdef UART_RX_BREAK_DET_EN
  localparam bit BRK_EN = 1'b1;
`else
  localparam bit BRK_EN = 1'b0;
`endif

  logic          CLK      = 1'b0;
  logic          Reset    = 1'b0;
  logic          RX_IN    = 1'b1;
  logic [PW-1:0] Prescale = PW'(8);
  logic          PAR_EN   = 1'b0;
  logic          PAR_TYP  = 1'b0;
  logic          sampled_data, sampled;
  logic [DW-1:0] P_Data   = '0;
  logic [PW-1:0] edge_cnt;
  logic          sample_en, deser_en, data_valid, par_err, stp_err, brk_det;

  int unsigned   checks = 0;
  int unsigned   errors = 0;
  int unsigned   cyc = 0;
  int unsigned   cur_half = 4;
  logic          inj_sampled = 1'b0;
  logic          inj_data = 1'b0;

  uart_rx_ctrl #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW)) dut (
    .CLK(CLK), .Reset(Reset), .RX_IN(RX_IN), .Prescale(Prescale),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .sampled_data(sampled_data),
    .sampled(sampled), .P_Data(P_Data),
`ifdef UART_RX_BREAK_DET_EN
    .brk_det(brk_det),
`endif
    .edge_cnt(edge_cnt), .sample_en(sample_en), .deser_en(deser_en),
    .data_valid(data_valid), .par_err(par_err), .stp_err(stp_err)
  );
`ifndef UART_RX_BREAK_DET_EN
  assign brk_det = 1'b0;
`endif

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  // Neighbour models: mid-bit sampler and LSB-first deserializer.
  assign sampled      = (sample_en && (edge_cnt == PW'(cur_half))) || inj_sampled;
  assign sampled_data = inj_sampled ? inj_data : RX_IN;
  always @(posedge CLK) if (deser_en && sampled) P_Data <= {sampled_data, P_Data[DW-1:1]};

  typedef struct { int unsigned cyc; logic [DW-1:0] data; } dv_rec_t;
  dv_rec_t     dv_q[$];
  dv_rec_t     exp_q[$];
  int unsigned brk_cnt = 0;
  bit          deser_seen = 1'b0;
  bit          dv_prev = 1'b0;

  task automatic check(input string name, input int unsigned got, input int unsigned exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  always @(posedge CLK) begin
    #1;
    if (data_valid) begin
      dv_q.push_back('{cyc, P_Data});
      check("dv_single_cycle", dv_prev, 0);
    end
    dv_prev = data_valid;
    if (brk_det)  brk_cnt++;
    if (deser_en) deser_seen = 1'b1;
  end

  typedef struct {
    int unsigned presc;
    bit pe, pt;
    logic [DW-1:0] data;
    bit pbit, stop, b2b;
    bit exp_dv, exp_par, exp_stp, exp_brk;
  } vec_t;

  function automatic vec_t mk(input int unsigned presc, input bit pe, input bit pt,
                              input logic [DW-1:0] data, input bit pbit, input bit stop,
                              input bit b2b, input bit dv, input bit par, input bit stp,
                              input bit brk);
    vec_t v;
    v.presc = presc; v.pe = pe; v.pt = pt; v.data = data; v.pbit = pbit;
    v.stop = stop; v.b2b = b2b; v.exp_dv = dv; v.exp_par = par;
    v.exp_stp = stp; v.exp_brk = brk;
    return v;
  endfunction

  // Reference: outcome of a frame from the line-level bits alone.
  function automatic void model(inout vec_t v);
    int unsigned ones;
    ones      = $countones(v.data) + int'(v.pbit);
    v.exp_par = v.pe && ((v.pt == PAR_ODD) ? (ones % 2 == 0) : (ones % 2 == 1));
    v.exp_brk = BRK_EN && (v.data == '0) && !v.stop;
    v.exp_stp = !v.stop && !v.exp_brk;
    v.exp_dv  = !v.exp_par && v.stop;
  endfunction

  // Start detect (1) + frame length before data_valid + registered data_valid (1).
  function automatic int unsigned latency(input vec_t v);
    return (2 + DW + int'(v.pe)) * v.presc - v.presc / 2 + 2;
  endfunction

  task automatic send_frame(input vec_t v);
    cur_half = v.presc / 2;
    Prescale = PW'(v.presc); PAR_EN = v.pe; PAR_TYP = v.pt;
    RX_IN    = 1'b0;
    if (v.exp_dv) exp_q.push_back('{cyc + latency(v), v.data});
    @(negedge CLK);
    Prescale = PW'((v.presc == PRESC_8) ? PRESC_32 : PRESC_8);
    PAR_EN   = ~v.pe; PAR_TYP = ~v.pt;
    repeat (v.presc - 1) @(negedge CLK);
    for (int i = 0; i < DW; i++) begin
      RX_IN = v.data[i];
      repeat (v.presc) @(negedge CLK);
    end
    if (v.pe) begin
      RX_IN = v.pbit;
      repeat (v.presc) @(negedge CLK);
    end
    RX_IN = v.stop;
    if (v.stop) repeat (v.presc) @(negedge CLK);
    else begin
      // Bad stop held only past the mid-bit sample so the return to IDLE sees a high line.
      repeat (v.presc / 2 + 2) @(negedge CLK);
      RX_IN = 1'b1;
      repeat (v.presc / 2 - 2) @(negedge CLK);
    end
    RX_IN = 1'b1;
    if (!v.b2b) repeat (v.presc + $urandom_range(1, 5)) @(negedge CLK);
  endtask

  task automatic check_group(input vec_t v, input string tag);
    dv_rec_t g, e;
    check({tag, ".dv_count"}, dv_q.size(), exp_q.size());
    while (dv_q.size() > 0 && exp_q.size() > 0) begin
      g = dv_q.pop_front();
      e = exp_q.pop_front();
      check({tag, ".data"}, g.data, e.data);
      check({tag, ".dv_latency"}, g.cyc, e.cyc);
    end
    check({tag, ".par_err"}, par_err, v.exp_par);
    check({tag, ".stp_err"}, stp_err, v.exp_stp);
    check({tag, ".brk_det"}, brk_cnt, v.exp_brk);
    check({tag, ".idle"}, sample_en, 0);
    dv_q.delete(); exp_q.delete(); brk_cnt = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  vec_t vecs[7];
  vec_t rv;

  initial begin
    vecs[0] = mk(PRESC_8,  0, PAR_EVEN, 8'hA5, 0, 1, 0, 1, 0, 0, 0);
    vecs[1] = mk(PRESC_16, 1, PAR_EVEN, 8'h0F, 1, 1, 0, 0, 1, 0, 0);
    vecs[2] = mk(PRESC_16, 1, PAR_EVEN, 8'h0F, 0, 1, 0, 1, 0, 0, 0);
    vecs[3] = mk(PRESC_32, 1, PAR_ODD,  8'h55, 1, 1, 1, 1, 0, 0, 0);
    vecs[4] = mk(PRESC_32, 1, PAR_ODD,  8'h3C, 1, 1, 0, 1, 0, 0, 0);
    vecs[5] = mk(PRESC_8,  0, PAR_EVEN, 8'h12, 0, 0, 0, 0, 0, 1, 0);
    vecs[6] = mk(PRESC_16, 0, PAR_EVEN, 8'h00, 0, 0, 0, 0, 0, !BRK_EN, BRK_EN);

    #3;
    check("reset.edge_cnt", edge_cnt, 0);
    check("reset.sample_en", sample_en, 0);
    check("reset.deser_en", deser_en, 0);
    check("reset.data_valid", data_valid, 0);
    check("reset.par_err", par_err, 0);
    check("reset.stp_err", stp_err, 0);
    check("reset.brk_det", brk_det, 0);
    @(negedge CLK); Reset = 1'b1;
    repeat (3) @(negedge CLK);

    for (int i = 0; i < 7; i++) begin
      send_frame(vecs[i]);
      if (!vecs[i].b2b) check_group(vecs[i], $sformatf("vec%0d", i));
    end

    // A sampled strobe while idle must not touch the sticky flags.
    inj_data = 1'b1; inj_sampled = 1'b1;
    @(negedge CLK); inj_sampled = 1'b0;
    repeat (3) @(negedge CLK);
    check("idle_sampled.stp_err", stp_err, vecs[6].exp_stp);
    check("idle_sampled.sample_en", sample_en, 0);

    // False start: short low pulse, then line high again.
    cur_half = PRESC_16 / 2; Prescale = PW'(PRESC_16); PAR_EN = 1'b0;
    deser_seen = 1'b0;
    RX_IN = 1'b0; repeat (3) @(negedge CLK);
    RX_IN = 1'b1; repeat (32) @(negedge CLK);
    check("false_start.deser_en", deser_seen, 0);
    check("false_start.dv_count", dv_q.size(), 0);
    check("false_start.par_err", par_err, 0);
    check("false_start.stp_err", stp_err, 0);
    check("false_start.sample_en", sample_en, 0);
    dv_q.delete();

    // Reset in the middle of data bit 4.
    cur_half = PRESC_8 / 2; Prescale = PW'(PRESC_8); PAR_EN = 1'b0;
    RX_IN = 1'b0; repeat (PRESC_8) @(negedge CLK);
    for (int i = 0; i < 4; i++) begin
      RX_IN = 1'(i % 2); repeat (PRESC_8) @(negedge CLK);
    end
    RX_IN = 1'b1; repeat (4) @(negedge CLK);
    check("mid_reset.pre_deser_en", deser_en, 1);
    #2 Reset = 1'b0;
    #1;
    check("mid_reset.edge_cnt", edge_cnt, 0);
    check("mid_reset.sample_en", sample_en, 0);
    check("mid_reset.deser_en", deser_en, 0);
    check("mid_reset.data_valid", data_valid, 0);
    check("mid_reset.par_err", par_err, 0);
    check("mid_reset.stp_err", stp_err, 0);
    @(negedge CLK); Reset = 1'b1;
    repeat (4) @(negedge CLK);
    check("mid_reset.dv_count", dv_q.size(), 0);
    dv_q.delete();
    rv = mk(PRESC_8, 1, PAR_EVEN, 8'hC3, 0, 1, 0, 0, 0, 0, 0);
    model(rv);
    send_frame(rv);
    check_group(rv, "after_reset");

    for (int k = 0; k < 24; k++) begin
      case ($urandom_range(0, 2))
        0:       rv.presc = PRESC_8;
        1:       rv.presc = PRESC_16;
        default: rv.presc = PRESC_32;
      endcase
      rv.pe   = 1'($urandom_range(0, 1));
      rv.pt   = 1'($urandom_range(0, 1));
      rv.data = DW'($urandom);
      rv.pbit = 1'($urandom_range(0, 1));
      rv.stop = ($urandom_range(0, 5) != 0);
      rv.b2b  = rv.stop && ($urandom_range(0, 2) == 0) && (k != 23);
      model(rv);
      send_frame(rv);
      if (!rv.b2b) check_group(rv, $sformatf("rand%0d", k));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
